// File: rtl/gvt_min_reducer_pkg.sv
// rtl/gvt_min_reducer_pkg.sv - shared virtual-time types and ordering helper
package chronos;

    localparam int TS_W     = 32;
    localparam int TB_W     = 32;
    localparam int VT_MAX_W = 256;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [TB_W-1:0] tb;
    } vt_t;

    localparam vt_t VT_INF = '1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REDUCE = 1'b1
    } state_t;

    // {ts, tb} packed with ts on top makes lexicographic order plain unsigned
    // order; callers zero-extend, which preserves that order for any width.
    function automatic logic vt_lt(input logic [VT_MAX_W-1:0] a,
                                   input logic [VT_MAX_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/gvt_min_reducer_stage.sv
// rtl/gvt_min_reducer_stage.sv - one registered pairwise-min level of the GVT tree
module gvt_min_stage
    import chronos::*;
#(
    parameter int W    = 64,
    parameter int N_IN = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_IN*W-1:0]       in_data,
    output logic [(N_IN/2)*W-1:0]   out_data
);

    for (genvar i = 0; i < N_IN / 2; i++) begin : g_pair
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;

        assign a = in_data[2*i*W +: W];
        assign b = in_data[(2*i+1)*W +: W];

        // b wins only when strictly smaller, so exact ties keep the lower index
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                q <= '1;
            end else begin
                q <= vt_lt(VT_MAX_W'(b), VT_MAX_W'(a)) ? b : a;
            end
        end

        assign out_data[i*W +: W] = q;
    end

endmodule

// File: rtl/gvt_min_reducer.sv
// rtl/gvt_min_reducer.sv - periodic pipelined lexicographic-min GVT reduction
module gvt_min_reducer
    import chronos::*;
#(
    parameter int N_TILES        = 8,
    parameter int TS_WIDTH       = 32,
    parameter int TB_WIDTH       = 32,
    parameter int LOG_GVT_PERIOD = 5
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [N_TILES-1:0]                       tile_lvt_valid,
    input  logic [N_TILES*(TS_WIDTH+TB_WIDTH)-1:0]   tile_lvt,
    input  logic                                     gvt_freeze,
    output logic [TS_WIDTH+TB_WIDTH-1:0]             gvt,
    output logic                                     gvt_valid,
    output logic                                     busy,
    output logic                                     regress_err
);

    localparam int W     = TS_WIDTH + TB_WIDTH;
    localparam int L     = $clog2(N_TILES);
    localparam int N_PAD = 1 << L;
    localparam int LAT   = (L > 0) ? L : 1;
    localparam int LW    = $clog2(LAT) + 1;

    logic [LOG_GVT_PERIOD-1:0] cnt;
    state_t                    state;
    logic [LW-1:0]             lvl;
    logic                      sample_req;
    logic                      sample;
    logic [N_PAD*W-1:0]        leaf_in;
    logic [W-1:0]              result;

    assign sample_req = (cnt == '1) && !gvt_freeze;
    assign sample     = sample_req && (state == ST_IDLE);

    for (genvar i = 0; i < N_PAD; i++) begin : g_leaf
        if (i < N_TILES) begin : g_tile
            assign leaf_in[i*W +: W] = tile_lvt_valid[i] ? tile_lvt[i*W +: W] : {W{1'b1}};
        end else begin : g_pad
            assign leaf_in[i*W +: W] = {W{1'b1}};
        end
    end

    if (L == 0) begin : g_single
        logic [W-1:0] leaf_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                leaf_q <= '1;
            end else if (sample) begin
                leaf_q <= leaf_in;
            end
        end

        assign result = leaf_q;
    end else begin : g_tree
        // Levels stored back to back: level k holds N_PAD>>k words at offset 2*N_PAD-2*(N_PAD>>k).
        // Level 1 registers straight from the masked inputs on the sample edge.
        logic [(2*N_PAD-1)*W-1:0] tree;

        assign tree[N_PAD*W-1:0] = leaf_in;

        for (genvar k = 0; k < L; k++) begin : g_lvl
            localparam int NI = N_PAD >> k;
            localparam int OI = 2*N_PAD - 2*NI;
            localparam int OO = OI + NI;

            gvt_min_stage #(
                .W    (W),
                .N_IN (NI)
            ) u_stage (
                .clk      (clk),
                .rstn     (rstn),
                .in_data  (tree[OI*W +: NI*W]),
                .out_data (tree[OO*W +: (NI/2)*W])
            );
        end

        assign result = tree[(2*N_PAD-2)*W +: W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            state       <= ST_IDLE;
            lvl         <= '0;
            gvt         <= '0;
            gvt_valid   <= 1'b0;
            busy        <= 1'b0;
            regress_err <= 1'b0;
        end else begin
            gvt_valid <= 1'b0;
            if (!gvt_freeze) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample) begin
                        state <= ST_REDUCE;
                        busy  <= 1'b1;
                        lvl   <= '0;
                    end
                end
                ST_REDUCE: begin
                    if (lvl == LW'(LAT - 1)) begin
                        if (!vt_lt(VT_MAX_W'(result), VT_MAX_W'(gvt))) begin
                            gvt       <= result;
                            gvt_valid <= 1'b1;
                        end else begin
                            regress_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lvl <= lvl + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_no_sample_while_busy: assert property (@(posedge clk) disable iff (!rstn)
        !(sample_req && state == ST_REDUCE));

endmodule
